// File: rtl/manchester_deserializer.sv
// Manchester line receiver: hunts for a sync byte, then decodes each
// following 16-chip group into one byte on an AXI4-Stream master port.
// Any invalid chip pair in a locked word drops lock, so an idle line unlocks.
module manchester_deserializer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter bit         ONE_IS_HL = 1'b1
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       serial_in,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       locked,
    output logic       code_err,
    output logic       overflow
);

    // Chip-pair encoding of one byte, MSB pair first.
    function automatic logic [15:0] enc_byte(input logic [7:0] b);
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[15-2*k] = ONE_IS_HL ? b[7-k] : ~b[7-k];
            w[14-2*k] = ~w[15-2*k];
        end
        return w;
    endfunction

    // A word is legal only when every pair holds two different chips.
    function automatic logic word_ok(input logic [15:0] w);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (w[15-2*k] == w[14-2*k]) ok = 1'b0;
        end
        return ok;
    endfunction

    // Recover the byte from a legal word; one chip of each pair carries the bit.
    function automatic logic [7:0] dec_word(input logic [15:0] w);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            b[7-k] = ONE_IS_HL ? w[15-2*k] : w[14-2*k];
        end
        return b;
    endfunction

    localparam logic [15:0] SYNC_CHIPS = enc_byte(SYNC_BYTE);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  chip_cnt;
    logic [3:0]  chip_cnt_nxt;
    logic [15:0] chip_sr;
    logic [15:0] sr_next;
    logic        word_done;
    logic        vld_p0;
    logic        byte_ok;
    logic        byte_bad;

    assign sr_next = {chip_sr[14:0], serial_in};
    assign locked  = (state == LOCKED);

    // Stage p0: chip capture into the 16-chip shift register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            chip_sr <= '0;
        end else begin
            chip_sr <= sr_next;
        end
    end

    // FSM state and chip counter registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= HUNT;
            chip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            chip_cnt <= chip_cnt_nxt;
        end
    end

    // Sync hunt, chip counting and lock loss on an illegal completed word.
    always_comb begin
        state_nxt    = state;
        chip_cnt_nxt = chip_cnt;
        word_done    = 1'b0;
        case (state)
            HUNT: begin
                if (sr_next == SYNC_CHIPS) begin
                    state_nxt    = LOCKED;
                    chip_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                chip_cnt_nxt = chip_cnt + 4'd1;
                if (chip_cnt == 4'd15) begin
                    word_done = 1'b1;
                    if (!word_ok(sr_next)) state_nxt = HUNT;
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // Mark that chip_sr holds a complete locked word for the output stage.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= word_done;
        end
    end

    // Stage p1: judge the completed word held in chip_sr.
    assign byte_ok  = vld_p0 &&  word_ok(chip_sr);
    assign byte_bad = vld_p0 && !word_ok(chip_sr);

    // Single-slot output register with overflow and code error pulses.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            code_err      <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            code_err <= byte_bad;
            overflow <= 1'b0;
            if (byte_ok) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= dec_word(chip_sr);
                    m_axis_tvalid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_manchester_deserializer.sv
// Directed bench for manchester_deserializer: sync hunt, decode latency,
// backpressure overflow, code violations, mid-byte reset, back-to-back bytes.
module tb_manchester_deserializer;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       serial_in;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       locked;
    logic       code_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ce_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] xq[$];
    int xc[$];

    manchester_deserializer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .serial_in     (serial_in),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .locked        (locked),
        .code_err      (code_err),
        .overflow      (overflow)
    );

    always #5 aclk = ~aclk;

    // Free-running cycle count for spacing between transfers.
    always @(posedge aclk) cyc <= cyc + 1;

    // Log transfers and error pulses away from the active edge.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (m_axis_tvalid && m_axis_tready) begin
                xq.push_back(m_axis_tdata);
                xc.push_back(cyc);
            end
            if (code_err) ce_cnt++;
            if (overflow) ov_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_chip(input logic c);
        serial_in = c;
        @(posedge aclk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_chip(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_chip(1'b0);
    endtask

    initial begin
        logic [15:0] w;

        // 1: reset, then idle line
        aresetn       = 1'b0;
        serial_in     = 1'b0;
        m_axis_tready = 1'b1;
        send_chip(1'b0);
        send_chip(1'b0);
        chk("reset_outputs", {m_axis_tdata, m_axis_tvalid, locked, code_err, overflow}, 32'h0);
        aresetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_chip(1'b0);
            chk("idle_quiet", {locked, m_axis_tvalid, code_err}, 32'h0);
        end

        // 2: sync then 3C with tready high
        xq.delete(); xc.delete();
        w = 16'h9966;
        for (int i = 15; i >= 1; i--) send_chip(w[i]);
        chk("lock_before_last_sync_chip", locked, 1'b0);
        send_chip(w[0]);
        chk("lock_after_last_sync_chip", locked, 1'b1);
        send_word(16'h5AA5);
        chk("t2_tvalid_at_16th_chip", m_axis_tvalid, 1'b0);
        send_chip(1'b0);
        chk("t2_tvalid_next_cycle", m_axis_tvalid, 1'b1);
        chk("t2_tdata", m_axis_tdata, 8'h3C);
        send_chip(1'b0);
        chk("t2_tvalid_one_cycle", m_axis_tvalid, 1'b0);
        idle(40);
        chk("t2_unlocked_by_idle", locked, 1'b0);
        chk("t2_xfer_count", xq.size(), 1);

        // 3: backpressure and overflow
        xq.delete(); xc.delete();
        ov_cnt = 0;
        m_axis_tready = 1'b0;
        send_word(16'h9966);
        send_word(16'h5AA5);
        w = 16'hA55A;
        send_chip(w[15]);
        chk("t3_tvalid_loaded", m_axis_tvalid, 1'b1);
        chk("t3_tdata_loaded", m_axis_tdata, 8'h3C);
        for (int i = 14; i >= 0; i--) send_chip(w[i]);
        chk("t3_tvalid_held", m_axis_tvalid, 1'b1);
        chk("t3_overflow_not_yet", overflow, 1'b0);
        send_chip(1'b0);
        chk("t3_overflow_pulse", overflow, 1'b1);
        chk("t3_tdata_kept", m_axis_tdata, 8'h3C);
        send_chip(1'b0);
        chk("t3_overflow_one_cycle", overflow, 1'b0);
        m_axis_tready = 1'b1;
        send_chip(1'b0);
        chk("t3_tvalid_after_xfer", m_axis_tvalid, 1'b0);
        idle(40);
        chk("t3_xfer_count", xq.size(), 1);
        chk("t3_xfer_data", xq[0], 8'h3C);
        chk("t3_overflow_count", ov_cnt, 1);

        // 4: code violation, then relock
        xq.delete(); xc.delete();
        ce_cnt = 0;
        send_word(16'h9966);
        send_word(16'h5AA4);
        idle(3);
        chk("t4_code_err_pulses", ce_cnt, 1);
        chk("t4_code_err_low_after", code_err, 1'b0);
        chk("t4_unlocked", locked, 1'b0);
        chk("t4_no_output", xq.size(), 0);
        send_word(16'h9966);
        send_word(16'h5AA5);
        send_chip(1'b0);
        chk("t4_relock_tvalid", m_axis_tvalid, 1'b1);
        chk("t4_relock_tdata", m_axis_tdata, 8'h3C);
        idle(40);

        // 5: reset mid-byte
        xq.delete(); xc.delete();
        send_word(16'h9966);
        w = 16'h5AA5;
        for (int i = 15; i >= 8; i--) send_chip(w[i]);
        chk("t5_locked_before_reset", locked, 1'b1);
        aresetn = 1'b0;
        send_chip(1'b0);
        chk("t5_reset_outputs", {m_axis_tdata, m_axis_tvalid, locked, code_err, overflow}, 32'h0);
        aresetn = 1'b1;
        for (int i = 7; i >= 0; i--) send_chip(w[i]);
        idle(3);
        chk("t5_no_output", xq.size(), 0);
        chk("t5_still_unlocked", locked, 1'b0);

        // 6: sync byte as data, back-to-back bytes
        xq.delete(); xc.delete();
        send_word(16'h9966);
        send_word(16'h9966);
        send_word(16'h5AA5);
        idle(2);
        chk("t6_locked", locked, 1'b1);
        chk("t6_xfer_count", xq.size(), 2);
        chk("t6_first_byte", xq[0], 8'hA5);
        chk("t6_second_byte", xq[1], 8'h3C);
        chk("t6_spacing", xc[1] - xc[0], 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
